// File: rtl/playback_sequencer.sv
// Plays back a stored digit sequence from RAM onto the display, one digit per two-second tick.
// Define PLAYBACK_GAP_EN to insert a blank tick period after every digit.
module playback_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] diff,
    input  logic       tick_2s,
    input  logic [3:0] ram_data,
    output logic [4:0] ram_addr,
    output logic [3:0] disp_digit,
    output logic       tick_en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StShow,
`ifdef PLAYBACK_GAP_EN
        StGap,
`endif
        StFinish
    } state_e;

    localparam logic [3:0] Blank = 4'hF;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [1:0] diff_q, diff_d;
    logic [3:0] disp_q, disp_d;
    logic       last;
    logic       adv;

    // Last index is N-1 = 4*diff+3.
    assign last = (idx_q == {diff_q, 2'b11});

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        disp_d  = disp_q;
        adv     = 1'b0;
        if (abort) begin
            // Idle already holds these values, so this also covers start+abort in idle.
            state_d = StIdle;
            idx_d   = 4'd0;
            disp_d  = Blank;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        diff_d  = diff;
                        idx_d   = 4'd0;
                        state_d = StFetch;
                    end
                end
                StFetch: state_d = StLatch;
                StLatch: begin
                    disp_d  = ram_data;
                    state_d = StShow;
                end
                StShow: begin
                    if (tick_2s) begin
`ifdef PLAYBACK_GAP_EN
                        state_d = StGap;
                        disp_d  = Blank;
`else
                        adv = 1'b1;
`endif
                    end
                end
`ifdef PLAYBACK_GAP_EN
                StGap: begin
                    if (tick_2s) begin
                        adv = 1'b1;
                    end
                end
`endif
                StFinish: begin
                    state_d = StIdle;
                    idx_d   = 4'd0;
                end
                default: state_d = StIdle;
            endcase
            if (adv) begin
                if (last) begin
                    state_d = StFinish;
                    disp_d  = Blank;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StFetch;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            diff_q  <= 2'd0;
            disp_q  <= Blank;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            diff_q  <= diff_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        ram_addr   = {1'b0, idx_q};
        disp_digit = disp_q;
        busy       = (state_q != StIdle);
        done       = (state_q == StFinish);
        tick_en    = (state_q == StShow);
`ifdef PLAYBACK_GAP_EN
        tick_en    = (state_q == StShow) || (state_q == StGap);
`endif
    end

endmodule

// File: tb/tb_playback_sequencer.sv
// Randomized directed bench for playback_sequencer; the expected digit and address streams
// are derived from the RAM contents and sequence length N = 4*(diff+1).
module tb_playback_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] diff;
    logic       tick_2s;
    logic [3:0] ram_data;
    logic [4:0] ram_addr;
    logic [3:0] disp_digit;
    logic       tick_en;
    logic       busy;
    logic       done;

`ifdef PLAYBACK_GAP_EN
    localparam bit GapEn = 1'b1;
`else
    localparam bit GapEn = 1'b0;
`endif

    int         checks = 0;
    int         failures = 0;
    logic [3:0] mem [0:15];
    logic [3:0] log_disp [$];
    logic [4:0] log_addr [$];
    int         done_cnt = 0;
    logic       prev_te = 1'b0;
    logic       prev_done = 1'b0;
    logic [3:0] prev_disp = 4'hF;
    logic       force_tick = 1'b0;
    int         tcnt = 0;

    playback_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .diff       (diff),
        .tick_2s    (tick_2s),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .disp_digit (disp_digit),
        .tick_en    (tick_en),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid one cycle after the address.
    always @(posedge clk) ram_data <= mem[ram_addr[3:0]];

    // Free-running two-second tick, one pulse every 20 cycles, plus a forced pulse on demand.
    initial begin
        tick_2s = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            tcnt++;
            tick_2s = force_tick || (tcnt % 20 == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record each displayed value inside tick_en windows and the address at each window start.
    always @(negedge clk) begin
        if (tick_en && (!prev_te || disp_digit !== prev_disp)) begin
            log_disp.push_back(disp_digit);
            if (!prev_te) log_addr.push_back(ram_addr);
        end
        if (done) done_cnt++;
        if (prev_done) begin
            check("busy_after_done", 32'(busy), 32'd0);
            check("done_one_cycle", 32'(done), 32'd0);
        end
        prev_te   = tick_en;
        prev_disp = disp_digit;
        prev_done = done;
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_disp"}, 32'(disp_digit), 32'hF);
        check({tag, "_tick_en"}, 32'(tick_en), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 14));
    endtask

    // Runs one playback with captured difficulty d; at loop cycle 'inject' a second start
    // is pulsed and diff is moved to 2, neither of which may affect the run.
    task automatic run_play(input string tag, input logic [1:0] d, input int inject);
        int n;
        int budget;
        bit seen;
        int k;
        n = 4 * (int'(d) + 1);
        log_disp.delete();
        log_addr.delete();
        done_cnt = 0;
        @(negedge clk);
        diff  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        budget = 2 * n * 20 + 100;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (c == inject) begin
                start = 1'b1;
                diff  = 2'd2;
            end else begin
                start = 1'b0;
            end
            if (done_cnt != 0) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check_idle({tag, "_end"});
        check({tag, "_addr_count"}, 32'(log_addr.size()), 32'(n));
        check({tag, "_period_count"}, 32'(log_disp.size()), 32'(GapEn ? 2 * n : n));
        k = 0;
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, (i < log_addr.size()) ? 32'(log_addr[i]) : 32'hxxxxxxxx,
                  32'(i));
            check({tag, "_digit"}, (k < log_disp.size()) ? 32'(log_disp[k]) : 32'hxxxxxxxx,
                  32'(mem[i]));
            k++;
            if (GapEn) begin
                check({tag, "_gap"}, (k < log_disp.size()) ? 32'(log_disp[k]) : 32'hxxxxxxxx,
                      32'hF);
                k++;
            end
        end
    endtask

    initial begin
        bit found;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        diff  = 2'd0;
        for (int i = 0; i < 16; i++) mem[i] = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("reset");
        check("reset_addr", 32'(ram_addr), 32'd0);

        // Fixed four-digit sequence.
        mem[0] = 4'd3; mem[1] = 4'd7; mem[2] = 4'd1; mem[3] = 4'd9;
        run_play("diff0", 2'd0, -1);

        // Longest sequence with random contents.
        fill_random();
        run_play("diff3", 2'd3, -1);

        // Restart attempt and diff change mid-playback.
        fill_random();
        run_play("restart", 2'd0, 30);
        diff = 2'd0;

        // Abort during the third digit, with a coincident tick.
        fill_random();
        done_cnt = 0;
        @(negedge clk);
        diff  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (tick_en && ram_addr == 5'd2) found = 1'b1;
        end
        check("abort_reach_digit2", 32'(found), 32'd1);
        abort      = 1'b1;
        force_tick = 1'b1;
        @(negedge clk);
        abort      = 1'b0;
        force_tick = 1'b0;
        check_idle("abort");
        repeat (50) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_stay_idle", 32'(busy), 32'd0);

        // Start and abort together in idle.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort");
        repeat (5) @(negedge clk);
        check("start_abort_stay", 32'(busy), 32'd0);

        // Reset in the middle of playback (gap period when present).
        fill_random();
        @(negedge clk);
        diff  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (tick_en && (GapEn ? (disp_digit == 4'hF) : (ram_addr == 5'd1))) found = 1'b1;
        end
        check("rst_reach_gap", 32'(found), 32'd1);
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_idle("mid_reset");
        check("mid_reset_addr", 32'(ram_addr), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_reset_stay", 32'(busy), 32'd0);

        // A normal random run after reset.
        fill_random();
        run_play("post_reset", 2'($urandom_range(0, 3)), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
